receiver: RTL and testbench

// - Far-end partner of the GPO/INTR transmitter. Captures a 23-bit word from GPI on each

---
 rtl/receiver_pkg.sv | 5 +
 rtl/rx_sync_fifo.sv | 49 ++++
 rtl/receiver.sv | 78 +++++++
 tb/tb_receiver.sv | 132 +++++++++++++
 4 files changed

// File: rtl/receiver_pkg.sv
// receiver_pkg: shared defaults and the strobe-edge FSM state type
package receiver_pkg;
  localparam int DATA_W_DEF = 23;
  typedef enum logic {IDLE, LOW} state_t;
endpackage

// File: rtl/rx_sync_fifo.sv
// rx_sync_fifo: show-ahead FIFO with registered head word that holds while empty
module rx_sync_fifo #(
  parameter int DATA_W = 23,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic [DATA_W-1:0] r_data;
  logic w_wr, w_rd;
  logic [AW-1:0] w_rd_n;
  logic [CW-1:0] w_cnt_n;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data  = r_data;
  assign w_wr    = i_push & (~o_full | i_pop);
  assign w_rd    = i_pop & ~o_empty;
  assign w_rd_n  = r_rd + AW'(w_rd);
  assign w_cnt_n = r_count + CW'(w_wr) - CW'(w_rd);
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_data  <= '0;
    end else begin
      if (w_wr) r_mem[r_wr] <= i_data;
      r_wr    <= r_wr + AW'(w_wr);
      r_rd    <= w_rd_n;
      r_count <= w_cnt_n;
      // next head may be the word being written this very cycle
      if (w_cnt_n != '0) r_data <= (w_wr && w_rd_n == r_wr) ? i_data : r_mem[w_rd_n];
    end
  end
endmodule

// File: rtl/receiver.sv
// receiver: captures GPI on each INTR falling edge into a FIFO drained by valid/ready
module receiver
  import receiver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] GPI,
  input  logic              INTR,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              clear_ovf,
  output logic              overflow,
  output logic [CW-1:0]     fifo_count
);
  logic w_intr_s;
  logic [DATA_W-1:0] w_gpi_s;
  state_t r_state, w_next;
  logic w_push, w_pop, w_full, w_empty, w_drop;
  logic r_ovf;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_intr_s = INTR;
      assign w_gpi_s  = GPI;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_intr;
      logic [DATA_W-1:0] r_gpi [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_intr <= '1;
          for (int i = 0; i < SYNC_STAGES; i++) r_gpi[i] <= '0;
        end else begin
          r_intr[0] <= INTR;
          r_gpi[0]  <= GPI;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_intr[i] <= r_intr[i-1];
            r_gpi[i]  <= r_gpi[i-1];
          end
        end
      end
      assign w_intr_s = r_intr[SYNC_STAGES-1];
      assign w_gpi_s  = r_gpi[SYNC_STAGES-1];
    end
  endgenerate
  always_ff @(posedge clk) r_state <= !reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    if (r_state == IDLE) begin
      w_push = ~w_intr_s;
      w_next = w_intr_s ? IDLE : LOW;
    end else begin
      w_next = w_intr_s ? IDLE : LOW;
    end
  end
  assign rx_valid = ~w_empty;
  assign w_pop    = rx_valid & rx_ready;
  assign w_drop   = w_push & w_full & ~w_pop;
  // a drop in the same cycle as clear_ovf keeps the flag set
  always_ff @(posedge clk) r_ovf <= !reset ? 1'b0 : w_drop ? 1'b1 : clear_ovf ? 1'b0 : r_ovf;
  assign overflow = r_ovf;
  rx_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (w_gpi_s),
    .i_pop   (w_pop),
    .o_data  (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed and random stimulus against a queue-based model of the receiver
module tb_receiver;
  localparam int DW = 23, DEPTH = 4, SYNC = 2;
  logic clk = 0, reset = 0, INTR = 1, rx_ready = 0, clear_ovf = 0;
  logic [DW-1:0] GPI = '0, rx_data;
  logic rx_valid, overflow;
  logic [2:0] fifo_count;
  int checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] mq [$];
  logic [DW-1:0] pd_dat [$];
  int pd_due [$];
  logic m_ovf = 0, m_prev = 1;
  logic [DW-1:0] m_last = '0;

  receiver #(.DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .GPI(GPI), .INTR(INTR), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .clear_ovf(clear_ovf), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    bit pop, drop;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      mq.delete(); pd_due.delete(); pd_dat.delete();
      m_ovf = 0; m_last = '0; m_prev = 1;
    end else begin
      pop = (mq.size() > 0) && rx_ready;
      drop = 0;
      if (m_prev && !INTR) begin pd_due.push_back(cyc + SYNC); pd_dat.push_back(GPI); end
      m_prev = INTR;
      if (pop) void'(mq.pop_front());
      if (pd_due.size() > 0 && pd_due[0] == cyc) begin
        if (mq.size() < DEPTH) mq.push_back(pd_dat[0]); else drop = 1;
        void'(pd_due.pop_front()); void'(pd_dat.pop_front());
      end
      if (drop) m_ovf = 1; else if (clear_ovf) m_ovf = 0;
      if (mq.size() > 0) m_last = mq[0];
    end
    #1;
    chk("rx_valid", 32'(rx_valid), 32'(mq.size() > 0));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rx_data", 32'(rx_data), 32'(m_last));
  endtask

  task automatic strobe(input logic [DW-1:0] d, input int len);
    GPI = d; INTR = 0;
    repeat (len) tick();
    INTR = 1;
    tick();
  endtask

  task automatic pop_expect(input logic [DW-1:0] d);
    chk("pop_valid", 32'(rx_valid), 32'd1);
    chk("pop_data", 32'(rx_data), 32'(d));
    rx_ready = 1; tick(); rx_ready = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin INTR = i[0]; tick(); end
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_valid", 32'(rx_valid), 32'd0);
    INTR = 0; reset = 1; INTR = 1;
    repeat (4) tick();
    chk("post_reset_count", 32'(fifo_count), 32'd0);

    GPI = 23'h2A5A5A; INTR = 0; tick(); INTR = 1; GPI = '0;
    tick();
    chk("single_latency", 32'(rx_valid), 32'd0);
    tick();
    chk("single_valid", 32'(rx_valid), 32'd1);
    chk("single_data", 32'(rx_data), 32'h2A5A5A);
    pop_expect(23'h2A5A5A);
    chk("single_popped", 32'(fifo_count), 32'd0);

    strobe(23'h000123, 10);
    repeat (3) tick();
    chk("held_count", 32'(fifo_count), 32'd1);
    pop_expect(23'h000123);

    for (int i = 1; i <= 5; i++) strobe(DW'(i), 1);
    repeat (3) tick();
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) pop_expect(DW'(i));
    clear_ovf = 1; tick(); clear_ovf = 0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    for (int i = 1; i <= 4; i++) strobe(DW'(i), 1);
    repeat (3) tick();
    GPI = 23'd6; INTR = 0; tick(); INTR = 1;
    tick();
    rx_ready = 1; tick(); rx_ready = 0;
    chk("fullpp_count", 32'(fifo_count), 32'd4);
    chk("fullpp_ovf", 32'(overflow), 32'd0);
    pop_expect(23'd2); pop_expect(23'd3); pop_expect(23'd4); pop_expect(23'd6);

    strobe(23'h11, 1); strobe(23'h22, 1);
    repeat (2) tick();
    INTR = 0; GPI = 23'h33; tick(); INTR = 1;
    reset = 0; tick(); reset = 1;
    chk("midreset_valid", 32'(rx_valid), 32'd0);
    repeat (4) tick();
    chk("midreset_count", 32'(fifo_count), 32'd0);

    for (int n = 0; n < 600; n++) begin
      INTR = ($urandom_range(0, 2) != 0);
      GPI = DW'($urandom());
      rx_ready = ($urandom_range(0, 2) == 0);
      clear_ovf = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 149) != 0);
      tick();
    end
    reset = 1; INTR = 1; rx_ready = 1; clear_ovf = 0;
    repeat (10) tick();
    chk("drain_empty", 32'(fifo_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
